// File: rtl/klein_accum_ctrl.sv
// Klein compensated-summation sequencer.
// klein_step: one element of second-order (Klein) compensated summation on
// unsigned wrap-around words, followed by a fixed-depth register pipeline.
// klein_accum_ctrl: accepts elements, holds them stable at the step inputs for
// the full pipeline depth, writes the step results back, and on the last
// element of a vector presents the accumulators and their combined total.

module klein_step #(
    parameter int EXP_WIDTH_I  = 5,
    parameter int MANT_WIDTH_I = 2,
    parameter int STEP_LATENCY = 9
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   elem_i,
    input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   sum_i,
    input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   cs_i,
    input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   ccs_i,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   sum_o,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   cs_o,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   ccs_o
);
    localparam int W = 1 + EXP_WIDTH_I + MANT_WIDTH_I;

    logic [W-1:0] t_s;
    logic [W-1:0] c_s;
    logic [W-1:0] t2_s;
    logic [W-1:0] cc_s;
    logic [W-1:0] ccs_next_s;

    logic [W-1:0] sum_pipe_r [STEP_LATENCY];
    logic [W-1:0] cs_pipe_r  [STEP_LATENCY];
    logic [W-1:0] ccs_pipe_r [STEP_LATENCY];

    // Klein update: first- and second-order error terms, larger operand first.
    always_comb begin
        t_s = sum_i + elem_i;
        if (sum_i >= elem_i) begin
            c_s = (sum_i - t_s) + elem_i;
        end else begin
            c_s = (elem_i - t_s) + sum_i;
        end
        t2_s = cs_i + c_s;
        if (cs_i >= c_s) begin
            cc_s = (cs_i - t2_s) + c_s;
        end else begin
            cc_s = (c_s - t2_s) + cs_i;
        end
        ccs_next_s = ccs_i + cc_s;
    end

    // Delay line giving the step its fixed latency from stable inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STEP_LATENCY; i++) begin
                sum_pipe_r[i] <= '0;
                cs_pipe_r[i]  <= '0;
                ccs_pipe_r[i] <= '0;
            end
        end else begin
            sum_pipe_r[0] <= t_s;
            cs_pipe_r[0]  <= t2_s;
            ccs_pipe_r[0] <= ccs_next_s;
            for (int i = 1; i < STEP_LATENCY; i++) begin
                sum_pipe_r[i] <= sum_pipe_r[i-1];
                cs_pipe_r[i]  <= cs_pipe_r[i-1];
                ccs_pipe_r[i] <= ccs_pipe_r[i-1];
            end
        end
    end

    assign sum_o = sum_pipe_r[STEP_LATENCY-1];
    assign cs_o  = cs_pipe_r[STEP_LATENCY-1];
    assign ccs_o = ccs_pipe_r[STEP_LATENCY-1];
endmodule

module klein_accum_ctrl #(
    parameter int EXP_WIDTH_I  = 5,
    parameter int MANT_WIDTH_I = 2,
    parameter int STEP_LATENCY = 9
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   in_data_i,
    input  logic                                in_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_sum_o,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_cs_o,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_ccs_o,
    output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_result_o
);
    localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I;
    localparam int CNT_W       = $clog2(STEP_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [BIT_WIDTH_I-1:0] elem_r;
    logic                   last_r;
    logic [BIT_WIDTH_I-1:0] sum_r;
    logic [BIT_WIDTH_I-1:0] cs_r;
    logic [BIT_WIDTH_I-1:0] ccs_r;
    logic [CNT_W-1:0]       cnt_r;

    logic [BIT_WIDTH_I-1:0] out_sum_r;
    logic [BIT_WIDTH_I-1:0] out_cs_r;
    logic [BIT_WIDTH_I-1:0] out_ccs_r;
    logic [BIT_WIDTH_I-1:0] out_result_r;

    logic [BIT_WIDTH_I-1:0] step_sum_s;
    logic [BIT_WIDTH_I-1:0] step_cs_s;
    logic [BIT_WIDTH_I-1:0] step_ccs_s;
    logic                   capture_s;
    logic                   in_ready_s;
    logic                   out_valid_s;

    // Step inputs come only from registers so they stay stable while it settles.
    klein_step #(
        .EXP_WIDTH_I  (EXP_WIDTH_I),
        .MANT_WIDTH_I (MANT_WIDTH_I),
        .STEP_LATENCY (STEP_LATENCY)
    ) u_step (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .elem_i (elem_r),
        .sum_i  (sum_r),
        .cs_i   (cs_r),
        .ccs_i  (ccs_r),
        .sum_o  (step_sum_s),
        .cs_o   (step_cs_s),
        .ccs_o  (step_ccs_s)
    );

    assign capture_s = (state_r == ST_RUN) && (cnt_r == CNT_MAX);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (capture_s) begin
                    if (last_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake flags decoded from the registered state only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_RUN: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Element latch, latency counter, accumulators and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elem_r       <= '0;
            last_r       <= 1'b0;
            cnt_r        <= '0;
            sum_r        <= '0;
            cs_r         <= '0;
            ccs_r        <= '0;
            out_sum_r    <= '0;
            out_cs_r     <= '0;
            out_ccs_r    <= '0;
            out_result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        elem_r <= in_data_i;
                        last_r <= in_last_i;
                        cnt_r  <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (capture_s) begin
                        sum_r <= step_sum_s;
                        cs_r  <= step_cs_s;
                        ccs_r <= step_ccs_s;
                        if (last_r) begin
                            out_sum_r    <= step_sum_s;
                            out_cs_r     <= step_cs_s;
                            out_ccs_r    <= step_ccs_s;
                            out_result_r <= step_sum_s + step_cs_s + step_ccs_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        sum_r <= '0;
                        cs_r  <= '0;
                        ccs_r <= '0;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_s;
    assign out_valid_o  = out_valid_s;
    assign out_sum_o    = out_sum_r;
    assign out_cs_o     = out_cs_r;
    assign out_ccs_o    = out_ccs_r;
    assign out_result_o = out_result_r;
endmodule

// File: tb/tb_klein_accum_ctrl.sv
// Directed bench for klein_accum_ctrl with a result scoreboard.
module tb_klein_accum_ctrl;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [7:0] out_cs;
    logic [7:0] out_ccs;
    logic [7:0] out_result;

    typedef struct packed {
        logic [7:0] sum;
        logic [7:0] cs;
        logic [7:0] ccs;
        logic [7:0] res;
    } res_t;

    res_t       sb[$];
    logic [7:0] model_sum;
    int         checks;
    int         errors;
    int         cyc;
    int         last_accept;

    klein_accum_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sum_o    (out_sum),
        .out_cs_o     (out_cs),
        .out_ccs_o    (out_ccs),
        .out_result_o (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Integer addition mod 256 is exact, so both compensation terms stay zero.
    task automatic model_push(input logic [7:0] d, input logic l);
        res_t e;
        model_sum = model_sum + d;
        if (l) begin
            e.sum = model_sum;
            e.cs  = 8'd0;
            e.ccs = 8'd0;
            e.res = model_sum;
            sb.push_back(e);
            model_sum = 8'd0;
        end
    endtask

    // Entered and left at a negedge.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        last_accept = cyc;
        in_valid = 1'b0;
        model_push(d, l);
    endtask

    task automatic get_result(input int hold);
        int   n;
        res_t e;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", {31'd0, out_valid}, 32'd1);
        check("latency", cyc - last_accept, 32'd10);
        check("ready_in_done", {31'd0, in_ready}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            check("sb_empty", 32'd0, 32'd1);
            e = '0;
        end
        check("out_sum", {24'd0, out_sum}, {24'd0, e.sum});
        check("out_cs", {24'd0, out_cs}, {24'd0, e.cs});
        check("out_ccs", {24'd0, out_ccs}, {24'd0, e.ccs});
        check("out_result", {24'd0, out_result}, {24'd0, e.res});
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_sum", {24'd0, out_sum}, {24'd0, e.sum});
            check("hold_result", {24'd0, out_result}, {24'd0, e.res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] tp [4];
        int         acc [4];
        int         n;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_accept = 0;
        model_sum   = 8'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        tp[0] = 8'd10; tp[1] = 8'd20; tp[2] = 8'd30; tp[3] = 8'd40;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {24'd0, out_sum}, 32'd0);
        check("rst_cs", {24'd0, out_cs}, 32'd0);
        check("rst_ccs", {24'd0, out_ccs}, 32'd0);
        check("rst_result", {24'd0, out_result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector 3,5,7.
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        get_result(0);

        // Wrap-around 200+100.
        send(8'd200, 1'b0);
        send(8'd100, 1'b1);
        get_result(0);

        // Throughput with in_valid held high.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = tp[k];
            in_last  = (k == 3);
            n = 0;
            while (!in_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (k > 0) check("tp_low_cycles", n, 32'd10);
            acc[k] = cyc + 1;
            model_push(tp[k], k == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) check("tp_spacing", acc[k] - acc[k-1], 32'd11);
        last_accept = acc[3];
        get_result(0);

        // Backpressure, then a vector proving the accumulators were cleared.
        send(8'd50, 1'b0);
        send(8'd60, 1'b1);
        get_result(5);
        send(8'd1, 1'b1);
        get_result(0);

        // Single element.
        send(8'd42, 1'b1);
        get_result(0);

        // Reset in the middle of RUN.
        send(8'd9, 1'b0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_sum", {24'd0, out_sum}, 32'd0);
        model_sum = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd2, 1'b1);
        get_result(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/klein_accum_ctrl.md
# klein_accum_ctrl

Sequencing controller for the Klein compensated-summation datapath. It accepts a stream of floating-point elements over a valid/ready handshake and owns the running `sum`/`cs`/`ccs` state. It instantiates one `klein_step` and presents each element together with the current state. Inputs are held stable for the step's full pipeline depth, then the step outputs are written back. On the last element of a vector it emits the three accumulators and their combined result over a second valid/ready handshake.

## Interface
- EXP_WIDTH_I, 5, exponent width, passed to `klein_step`
- MANT_WIDTH_I, 2, mantissa width, passed to `klein_step`
- STEP_LATENCY, 9, register depth of `klein_step` from stable inputs to settled outputs
- BIT_WIDTH_I (localparam), 1+EXP_WIDTH_I+MANT_WIDTH_I, element word width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  element valid
- in_ready_o  out  1  controller can accept an element
- in_data_i  in  BIT_WIDTH_I  element
- in_last_i  in  1  element is the final one of the vector
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts the result
- out_sum_o  out  BIT_WIDTH_I  final `sum`
- out_cs_o  out  BIT_WIDTH_I  final `cs`
- out_ccs_o  out  BIT_WIDTH_I  final `ccs`
- out_result_o  out  BIT_WIDTH_I  sum+cs+ccs

## Operation
- Internal registers:
  - `elem_q`, `last_q`
  - `sum_q`, `cs_q`, `ccs_q`
  - counter `cnt`, width clog2(STEP_LATENCY+1)
  - FSM `state`
- `klein_step` inputs are driven only from registers: elem_i=`elem_q`, sum_i=`sum_q`, cs_i=`cs_q`, ccs_i=`ccs_q`.
- Arithmetic matches `klein_step`: words are unsigned BIT_WIDTH_I-bit values, `+` wraps modulo 2^BIT_WIDTH_I, and no flags are produced.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i: load `elem_q`←in_data_i, `last_q`←in_last_i, `cnt`←0, go to RUN.
  - RUN: in_ready_o=0. `cnt` increments each cycle.
    - When `cnt`==STEP_LATENCY (capture cycle): `sum_q`←sum_o, `cs_q`←cs_o, `ccs_q`←ccs_o.
    - If `last_q`=1, also load the output registers, with out_result_o←sum_o+cs_o+ccs_o, and go to DONE. Otherwise go to IDLE.
  - DONE: out_valid_o=1, in_ready_o=0. On out_ready_i: clear `sum_q`, `cs_q`, `ccs_q` to 0, go to IDLE.
- Output registers hold their value outside DONE. They are overwritten only by the next vector's capture.
- A single-element vector (in_last_i on the first element) is legal and behaves identically.
- There is no way to abort a vector other than reset.

## Timing
- Reset values (async, immediate): state=IDLE, in_ready_o=1, out_valid_o=0, all out_* data=0, all internal registers=0.
- Element throughput: the accept edge is A and the capture edge is A+STEP_LATENCY+1 (A+10 at default). in_ready_o rises in the cycle after capture. The next accept is possible no earlier than edge A+STEP_LATENCY+2, giving 11 cycles per element.
- Result latency: out_valid_o is high in the cycle following the last element's capture edge, i.e. 10 edges after the last accept at default.
- in_ready_o and out_valid_o are never both high.
- With out_ready_i held low, out_valid_o and all out_* data stay constant for as long as out_ready_i is low.
- out_ready_i asserted on the first DONE cycle: the handshake completes on that edge, and in_ready_o=1 the next cycle.
- Inputs presented while in_ready_o=0 are ignored and must be held by the producer.
- Reset asserted in RUN or DONE:
  - Everything returns to reset values immediately.
  - The pending element and partial sums are lost.
  - `klein_step` is reset by the same rst_ni.

## Test plan
- Reset then elements 3, 5, 7 (last on 7), out_ready_i=1 -> out_sum_o=15, out_cs_o=0, out_ccs_o=0, out_result_o=15. out_valid_o rises exactly 10 edges after the accept of 7.
- Wrap: 200 then 100 (last) -> out_sum_o=44, out_result_o=44.
- Throughput: in_valid_i held high with 4 elements -> accepts on edges A, A+11, A+22, A+33. in_ready_o is low in between.
- Backpressure: out_ready_i low for 5 cycles in DONE -> outputs stable and in_ready_o=0 throughout. The handshake on cycle 6 is followed by in_ready_o=1. A second vector {1} then returns out_sum_o=1, proving the accumulators were cleared.
- Single element 42 with last -> out_result_o=42.
- Reset mid-RUN (after element 9, cnt=4) -> out_valid_o=0 and in_ready_o=1 immediately. A following vector {2} yields out_sum_o=2.
